// File: rtl/mem_pkg.sv
// mem_pkg: shared opcode and state encodings plus stack-pointer reset default for mem_access_ctrl
package mem_pkg;
  typedef enum logic [2:0] {
    OP_NOP, OP_LOAD, OP_STORE, OP_PUSH, OP_POP, OP_CALL, OP_RET, OP_RSVD
  } mem_op_e;
  typedef enum logic [1:0] {IDLE, SECOND_WR, SECOND_RD, RET_DONE} state_e;
  localparam logic [15:0] SP_RESET_DEFAULT = 16'h03FF;
endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: request, memory-strobe and result bus of mem_access_ctrl; fault exists only with MEM_BOUNDS_CHECK_EN
interface mem_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  mem_op;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        read_enable;
  logic        write_enable;
  logic [15:0] read_addr;
  logic [15:0] write_addr;
  logic [15:0] write_data;
  logic [15:0] memory_data_output;
  logic        result_valid;
  logic [31:0] result_data;
  logic [15:0] sp;
  logic        busy;
`ifdef MEM_BOUNDS_CHECK_EN
  logic        fault;
`endif
  modport master(
    output req_valid, mem_op, req_addr, req_wdata, memory_data_output,
`ifdef MEM_BOUNDS_CHECK_EN
    input fault,
`endif
    input req_ready, read_enable, write_enable, read_addr, write_addr, write_data,
    input result_valid, result_data, sp, busy
  );
  modport slave(
    input req_valid, mem_op, req_addr, req_wdata, memory_data_output,
`ifdef MEM_BOUNDS_CHECK_EN
    output fault,
`endif
    output req_ready, read_enable, write_enable, read_addr, write_addr, write_data,
    output result_valid, result_data, sp, busy
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: memory-stage load/store/stack/call controller; MEM_BOUNDS_CHECK_EN adds address bounds checking with a fault pulse
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int          N        = 10,
  parameter logic [15:0] SP_RESET = SP_RESET_DEFAULT
) (
  input logic              clk,
  input logic              rst,
  mem_access_ctrl_if.slave bus
);
`ifdef MEM_BOUNDS_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif
  state_e      state_q;
  logic [15:0] sp_q, lo_q;
  logic        busy_q, rv_q;
  mem_op_e     op;
  logic        accept, re, we, oob;
  logic [15:0] ra, wa, wd;
  assign op     = mem_op_e'(bus.mem_op);
  assign accept = bus.req_valid && !busy_q;
  always_comb begin
    re  = state_q == SECOND_RD || (accept && (op == OP_LOAD || op == OP_POP || op == OP_RET));
    we  = state_q == SECOND_WR || (accept && (op == OP_STORE || op == OP_PUSH || op == OP_CALL));
    ra  = state_q == SECOND_RD ? sp_q + 16'd2 : op == OP_LOAD ? bus.req_addr : sp_q + 16'd1;
    wa  = state_q == SECOND_WR ? sp_q - 16'd1 : op == OP_STORE ? bus.req_addr : sp_q;
    wd  = state_q == SECOND_WR ? lo_q : op == OP_CALL ? bus.req_wdata[31:16] : bus.req_wdata[15:0];
    oob = CHECK && (re || we) && |((re ? ra : wa) >> N);
  end
  assign bus.read_enable  = re && !oob && !rst;
  assign bus.write_enable = we && !oob && !rst;
  assign bus.read_addr    = ra;
  assign bus.write_addr   = wa;
  assign bus.write_data   = wd;
  assign bus.req_ready    = !busy_q;
  assign bus.busy         = busy_q;
  assign bus.sp           = sp_q;
  assign bus.result_valid = rv_q;
  assign bus.result_data  = !rv_q ? 32'h0 : state_q == RET_DONE ? {bus.memory_data_output, lo_q}
                                                                : {16'h0, bus.memory_data_output};
  always_ff @(posedge clk) begin
    rv_q <= 1'b0;
    if (rst) begin
      state_q <= IDLE;
      sp_q    <= SP_RESET;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else if (state_q == SECOND_WR) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      if (!oob) sp_q <= sp_q - 16'd2;
    end else if (state_q == SECOND_RD) begin
      lo_q    <= bus.memory_data_output;
      state_q <= oob ? IDLE : RET_DONE;
      busy_q  <= 1'b0;
      rv_q    <= !oob;
      if (!oob) sp_q <= sp_q + 16'd2;
    end else begin
      state_q <= IDLE;
      if (accept && !oob) begin
        rv_q    <= op == OP_LOAD || op == OP_POP;
        sp_q    <= op == OP_PUSH ? sp_q - 16'd1 : op == OP_POP ? sp_q + 16'd1 : sp_q;
        state_q <= op == OP_CALL ? SECOND_WR : op == OP_RET ? SECOND_RD : IDLE;
        busy_q  <= op == OP_CALL || op == OP_RET;
        if (op == OP_CALL) lo_q <= bus.req_wdata[15:0];
      end
    end
  end
`ifdef MEM_BOUNDS_CHECK_EN
  logic fault_q;
  always_ff @(posedge clk) fault_q <= !rst && oob;
  assign bus.fault = fault_q;
`endif
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: table-driven and sequence checks of mem_access_ctrl with a result scoreboard
module tb_mem_access_ctrl;
  import mem_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [15:0] mem [1024] = '{default: 16'h0};
  mem_access_ctrl_if ifc();
  mem_access_ctrl #(.N(10)) dut (.clk(clk), .rst(rst), .bus(ifc.slave));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (ifc.write_enable) mem[ifc.write_addr[9:0]] <= ifc.write_data;
    if (ifc.read_enable) ifc.memory_data_output <= mem[ifc.read_addr[9:0]];
  end
  typedef struct {
    logic        v;
    mem_op_e     op;
    logic [15:0] addr;
    logic [31:0] wd;
    logic        re, we;
    logic [15:0] a, d, sp;
    logic        has_res;
    logic [31:0] res;
  } vec_t;
  vec_t tbl[10];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, act, exp);
    end
  endtask
  task automatic step(input logic v, input mem_op_e op, input logic [15:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    ifc.req_valid = v;
    ifc.mem_op    = op;
    ifc.req_addr  = a;
    ifc.req_wdata = d;
  endtask
  always @(negedge clk) begin
    if (!rst && ifc.result_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL result_unexpected got %h exp none", ifc.result_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (ifc.result_data !== e) begin
          errors++;
          $display("FAIL result_data got %h exp %h", ifc.result_data, e);
        end
      end
    end
  end
  initial begin
    tbl[0] = '{1'b1, OP_STORE, 16'h0005, 32'h0000_00AB, 1'b0, 1'b1, 16'h0005, 16'h00AB, 16'h03FF, 1'b0, 32'h0};
    tbl[1] = '{1'b1, OP_LOAD,  16'h0005, 32'h0,         1'b1, 1'b0, 16'h0005, 16'h0,    16'h03FF, 1'b1, 32'h0000_00AB};
    tbl[2] = '{1'b1, OP_PUSH,  16'h0000, 32'h0000_1234, 1'b0, 1'b1, 16'h03FF, 16'h1234, 16'h03FF, 1'b0, 32'h0};
    tbl[3] = '{1'b1, OP_POP,   16'h0000, 32'h0,         1'b1, 1'b0, 16'h03FF, 16'h0,    16'h03FE, 1'b1, 32'h0000_1234};
    tbl[4] = '{1'b1, OP_STORE, 16'h03FF, 32'h0000_5555, 1'b0, 1'b1, 16'h03FF, 16'h5555, 16'h03FF, 1'b0, 32'h0};
    tbl[5] = '{1'b1, OP_LOAD,  16'h03FF, 32'h0,         1'b1, 1'b0, 16'h03FF, 16'h0,    16'h03FF, 1'b1, 32'h0000_5555};
    tbl[6] = '{1'b1, OP_NOP,   16'h0005, 32'h0000_0001, 1'b0, 1'b0, 16'h0,    16'h0,    16'h03FF, 1'b0, 32'h0};
    tbl[7] = '{1'b1, OP_RSVD,  16'h0005, 32'h0000_0001, 1'b0, 1'b0, 16'h0,    16'h0,    16'h03FF, 1'b0, 32'h0};
    tbl[8] = '{1'b0, OP_LOAD,  16'h0005, 32'h0,         1'b0, 1'b0, 16'h0,    16'h0,    16'h03FF, 1'b0, 32'h0};
    tbl[9] = '{1'b1, OP_STORE, 16'h0006, 32'hFFFF_0077, 1'b0, 1'b1, 16'h0006, 16'h0077, 16'h03FF, 1'b0, 32'h0};
    ifc.req_valid = 1'b0;
    ifc.mem_op    = OP_NOP;
    ifc.req_addr  = '0;
    ifc.req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_sp", ifc.sp, 16'h03FF);
    chk("rst_re", ifc.read_enable, 1'b0);
    chk("rst_we", ifc.write_enable, 1'b0);
    chk("rst_busy", ifc.busy, 1'b0);
    chk("rst_ready", ifc.req_ready, 1'b1);
    chk("rst_rv", ifc.result_valid, 1'b0);
`ifdef MEM_BOUNDS_CHECK_EN
    chk("rst_fault", ifc.fault, 1'b0);
`endif
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].v, tbl[i].op, tbl[i].addr, tbl[i].wd);
      @(negedge clk);
      chk($sformatf("v%0d_re", i), ifc.read_enable, tbl[i].re);
      chk($sformatf("v%0d_we", i), ifc.write_enable, tbl[i].we);
      chk($sformatf("v%0d_ready", i), ifc.req_ready, 1'b1);
      chk($sformatf("v%0d_sp", i), ifc.sp, tbl[i].sp);
      if (tbl[i].re) chk($sformatf("v%0d_raddr", i), ifc.read_addr, tbl[i].a);
      if (tbl[i].we) begin
        chk($sformatf("v%0d_waddr", i), ifc.write_addr, tbl[i].a);
        chk($sformatf("v%0d_wdata", i), ifc.write_data, tbl[i].d);
      end
      if (tbl[i].has_res) exp_q.push_back(tbl[i].res);
    end
    step(1'b1, OP_CALL, 16'h0, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("call0_we", ifc.write_enable, 1'b1);
    chk("call0_waddr", ifc.write_addr, 16'h03FF);
    chk("call0_wdata", ifc.write_data, 16'hDEAD);
    chk("call0_busy", ifc.busy, 1'b0);
    step(1'b1, OP_STORE, 16'h0009, 32'h0000_1111);
    @(negedge clk);
    chk("call1_busy", ifc.busy, 1'b1);
    chk("call1_ready", ifc.req_ready, 1'b0);
    chk("call1_we", ifc.write_enable, 1'b1);
    chk("call1_re", ifc.read_enable, 1'b0);
    chk("call1_waddr", ifc.write_addr, 16'h03FE);
    chk("call1_wdata", ifc.write_data, 16'hBEEF);
    step(1'b1, OP_RET, 16'h0, 32'h0);
    @(negedge clk);
    chk("ret0_busy", ifc.busy, 1'b0);
    chk("ret0_sp", ifc.sp, 16'h03FD);
    chk("ret0_re", ifc.read_enable, 1'b1);
    chk("ret0_raddr", ifc.read_addr, 16'h03FE);
    step(1'b1, OP_STORE, 16'h0009, 32'h0000_2222);
    @(negedge clk);
    chk("ret1_busy", ifc.busy, 1'b1);
    chk("ret1_ready", ifc.req_ready, 1'b0);
    chk("ret1_re", ifc.read_enable, 1'b1);
    chk("ret1_we", ifc.write_enable, 1'b0);
    chk("ret1_raddr", ifc.read_addr, 16'h03FF);
    exp_q.push_back(32'hDEAD_BEEF);
    step(1'b1, OP_LOAD, 16'h0005, 32'h0);
    @(negedge clk);
    chk("retdone_busy", ifc.busy, 1'b0);
    chk("retdone_ready", ifc.req_ready, 1'b1);
    chk("retdone_sp", ifc.sp, 16'h03FF);
    chk("retdone_re", ifc.read_enable, 1'b1);
    chk("retdone_raddr", ifc.read_addr, 16'h0005);
    exp_q.push_back(32'h0000_00AB);
    step(1'b0, OP_NOP, 16'h0, 32'h0);
    @(negedge clk);
    chk("busy_ignored_mem9", {16'h0, mem[9]}, 32'h0);
    step(1'b1, OP_PUSH, 16'h0, 32'h0000_4321);
    step(1'b1, OP_CALL, 16'h0, 32'hCAFE_F00D);
    @(negedge clk);
    chk("rcall_we", ifc.write_enable, 1'b1);
    chk("rcall_waddr", ifc.write_addr, 16'h03FE);
    @(posedge clk);
    #1;
    rst = 1'b1;
    ifc.req_valid = 1'b0;
    @(negedge clk);
    chk("rcall_rst_we", ifc.write_enable, 1'b0);
    chk("rcall_rst_re", ifc.read_enable, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rcall_sp", ifc.sp, 16'h03FF);
    chk("rcall_busy", ifc.busy, 1'b0);
    chk("rcall_we2", ifc.write_enable, 1'b0);
    chk("rcall_mem3fd", {16'h0, mem[10'h3FD]}, 32'h0);
    step(1'b1, OP_LOAD, 16'h0005, 32'h0);
    @(negedge clk);
    chk("rcall_idle_re", ifc.read_enable, 1'b1);
    chk("rcall_idle_ready", ifc.req_ready, 1'b1);
    exp_q.push_back(32'h0000_00AB);
`ifdef MEM_BOUNDS_CHECK_EN
    step(1'b1, OP_LOAD, 16'h0400, 32'h0);
    @(negedge clk);
    chk("oob_re", ifc.read_enable, 1'b0);
    chk("oob_fault0", ifc.fault, 1'b0);
    step(1'b0, OP_NOP, 16'h0, 32'h0);
    @(negedge clk);
    chk("oob_fault1", ifc.fault, 1'b1);
    chk("oob_rv", ifc.result_valid, 1'b0);
    chk("oob_sp", ifc.sp, 16'h03FF);
    step(1'b0, OP_NOP, 16'h0, 32'h0);
    @(negedge clk);
    chk("oob_fault2", ifc.fault, 1'b0);
`else
    for (int k = 1; k <= 1024; k++) step(1'b1, OP_PUSH, 16'h0, 32'(k));
    step(1'b0, OP_NOP, 16'h0, 32'h0);
    @(negedge clk);
    chk("wrap_sp_ffff", ifc.sp, 16'hFFFF);
    step(1'b1, OP_POP, 16'h0, 32'h0);
    @(negedge clk);
    chk("wrap_raddr", ifc.read_addr, 16'h0000);
    exp_q.push_back(32'h0000_0400);
    step(1'b0, OP_NOP, 16'h0, 32'h0);
    @(negedge clk);
    chk("wrap_sp_0", ifc.sp, 16'h0000);
`endif
    step(1'b0, OP_NOP, 16'h0, 32'h0);
    step(1'b0, OP_NOP, 16'h0, 32'h0);
    @(negedge clk);
    chk("results_pending", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter N, default 10: data-memory address width; valid addresses are 0 to (1<<N)-1.
REQ-002 Parameter SP_RESET, default 16'h03FF: stack-pointer value after reset.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 req_valid  in  1  memory-stage request present.
REQ-006 req_ready  out  1  request accepted this cycle; equals !busy.
REQ-007 mem_op  in  3  operation: 0 NOP, 1 LOAD, 2 STORE, 3 PUSH, 4 POP, 5 CALL, 6 RET, 7 reserved.
REQ-008 req_addr  in  16  LOAD/STORE address.
REQ-009 req_wdata  in  32  STORE/PUSH data in [15:0]; CALL return PC in [31:0].
REQ-010 read_enable, write_enable  out  1 each  strobes to data memory.
REQ-011 read_addr, write_addr  out  16 each  memory addresses.
REQ-012 write_data  out  16  memory write data.
REQ-013 memory_data_output  in  16  memory read data, valid at the posedge after read_enable.
REQ-014 result_valid  out  1  one-cycle pulse: result_data is valid.
REQ-015 result_data  out  32  LOAD/POP: {16'b0, word}; RET: {hi, lo}.
REQ-016 sp  out  16  current stack pointer.
REQ-017 busy  out  1  two-cycle operation in progress; upstream holds.

Function
REQ-018 FSM states: IDLE, SECOND_WR (CALL low word), SECOND_RD (RET high word), RET_DONE.
REQ-019 IDLE, accepted LOAD: read_enable=1, read_addr=req_addr the same cycle; result_valid=1 the next cycle, with result_data={16'b0, memory_data_output}.
REQ-020 IDLE, accepted STORE: write_enable=1, write_addr=req_addr, write_data=req_wdata[15:0] the same cycle; no result.
REQ-021 Stack convention: SP points to the next free word and grows downward.
REQ-022 PUSH: write word at SP; SP<=SP-1.
REQ-023 POP: read at SP+1; SP<=SP+1; result one cycle later, as for LOAD.
REQ-024 CALL, cycle 0: write req_wdata[31:16] at SP; latch low half; go to SECOND_WR with busy=1.
REQ-025 CALL, cycle 1: write low half at SP-1; SP<=SP-2; return to IDLE.
REQ-026 RET, cycle 0: read at SP+1 (low word); go to SECOND_RD with busy=1.
REQ-027 RET, cycle 1: latch low word; read at SP+2; SP<=SP+2; go to RET_DONE.
REQ-028 RET_DONE: result_valid=1, result_data={memory_data_output, low}; busy=0; a new request may be accepted in this cycle.
REQ-029 SP arithmetic is modulo 2^16 (0-1 wraps to 16'hFFFF).
REQ-030 NOP, reserved opcode, or req_valid=0: no strobes, no SP change.
REQ-031 While busy=1, req_ready=0 and request inputs are ignored.
REQ-032 At most one of read_enable/write_enable is asserted per cycle; strobes are combinational from state and inputs, and are 0 when inactive.

Reset
REQ-033 With rst=1 at posedge: FSM<=IDLE; SP<=SP_RESET; busy, result_valid, latched words <=0.
REQ-034 While rst=1: read_enable=0 and write_enable=0, even mid-CALL/RET; an aborted op leaves SP at SP_RESET.

Configuration
REQ-035 Macro MEM_BOUNDS_CHECK_EN defined: adds output fault (1 bit, registered pulse); any access address >= (1<<N) suppresses that strobe, leaves SP unchanged, aborts the op to IDLE, and pulses fault the next cycle with no result_valid.
REQ-036 Macro MEM_BOUNDS_CHECK_EN undefined: no fault port; addresses pass unchecked.

Structure
REQ-037 Shared package mem_pkg: mem_op encodings, FSM state enum, SP_RESET default.
REQ-038 Single module; no sub-modules (the SP adder and FSM are inline).

Verification
REQ-039 Reset -> sp=16'h03FF, all strobes 0, busy 0.
REQ-040 STORE addr 5, data 16'h00AB; then LOAD addr 5 -> write_addr=5; next cycle result_valid=1 and result_data=32'h000000AB.
REQ-041 PUSH 16'h1234; then POP -> write at 3FF, sp 3FE; read at 3FF, sp 3FF, result 16'h1234.
REQ-042 CALL 32'hDEAD_BEEF then RET -> writes DEAD@3FF, BEEF@3FE, sp 3FD, busy 1 cycle each; RET result 32'hDEADBEEF, sp 3FF.
REQ-043 rst asserted during SECOND_WR of CALL -> no second write; sp=3FF; FSM IDLE.
REQ-044 MEM_BOUNDS_CHECK_EN, N=10, LOAD addr 16'h0400 -> read_enable=0; fault pulse next cycle; no result_valid.
